// File: rtl/conv_3x3_stream_feeder.sv
// Streams weights then raster pixels for each (ch_out, ch_in) pass into a 3x3 conv core.
// Latency: read strobe at t, RAM data at t+1, registered beat on output at t+2.
// No backpressure: every valid beat is consumed. Optional macro FEEDER_PASS_GAP_EN stretches inter-pass idle.
module conv_3x3_stream_feeder #(
  parameter int DATA_WIDTH      = 32,
  parameter int IMAGE_WIDTH     = 64,
  parameter int IMAGE_HEIGHT    = 64,
  parameter int CHANNEL_NUM_IN  = 64,
  parameter int CHANNEL_NUM_OUT = 64,
  parameter int KERNEL          = 3,
  parameter int FMAP_ADDR_WIDTH = 18,
  parameter int W_ADDR_WIDTH    = 16,
  parameter int GAP_CYCLES      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       fmap_rd_en,
  output logic [FMAP_ADDR_WIDTH-1:0] fmap_rd_addr,
  input  logic [DATA_WIDTH-1:0]      fmap_rd_data,
  output logic                       w_rd_en,
  output logic [W_ADDR_WIDTH-1:0]    w_rd_addr,
  input  logic [DATA_WIDTH-1:0]      w_rd_data,
  output logic                       valid_out,
  output logic [DATA_WIDTH-1:0]      pxl_out,
  output logic                       valid_weight_out,
  output logic [DATA_WIDTH-1:0]      weight_out,
  output logic                       busy,
  output logic                       done
);

  localparam int KERNEL_SIZE = KERNEL * KERNEL;
  localparam int IMAGE_SIZE  = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int KW  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int PW  = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam int CIW = (CHANNEL_NUM_IN > 1) ? $clog2(CHANNEL_NUM_IN) : 1;
  localparam int COW = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;

  // NEXT is one bookkeeping cycle, optionally followed by extra idle cycles so the
  // conv line buffer can drain before the next pass starts.
`ifdef FEEDER_PASS_GAP_EN
  localparam int NEXT_LEN = GAP_CYCLES + 1;
`else
  localparam int NEXT_LEN = 1;
  logic unused_gap;
  assign unused_gap = (GAP_CYCLES != 0);
`endif
  localparam int GW = (NEXT_LEN > 1) ? $clog2(NEXT_LEN) : 1;

  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_P, NEXT, DONE} state_t;

  state_t           state, state_nxt;
  logic             armed;
  logic [KW-1:0]    k_cnt;
  logic [PW-1:0]    p_cnt;
  logic [CIW-1:0]   ch_in;
  logic [COW-1:0]   ch_out;
  logic [GW-1:0]    gap_cnt;
  logic             w_vld_q, p_vld_q;
  logic             w_last, p_last, in_last, out_last, gap_last;

  assign w_last   = (k_cnt == KW'(KERNEL_SIZE - 1));
  assign p_last   = (p_cnt == PW'(IMAGE_SIZE - 1));
  assign in_last  = (ch_in == CIW'(CHANNEL_NUM_IN - 1));
  assign out_last = (ch_out == COW'(CHANNEL_NUM_OUT - 1));
  assign gap_last = (gap_cnt == GW'(NEXT_LEN - 1));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Blocks a start that arrives on the same edge that reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  // Next-state logic and read strobes; the final pass skips the gap and goes straight to DONE.
  always_comb begin
    state_nxt  = state;
    w_rd_en    = 1'b0;
    fmap_rd_en = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (start && armed) state_nxt = LOAD_W;
      LOAD_W: begin
        w_rd_en = 1'b1;
        if (w_last) state_nxt = LOAD_P;
      end
      LOAD_P: begin
        fmap_rd_en = 1'b1;
        if (p_last) state_nxt = NEXT;
      end
      NEXT: begin
        if (in_last && out_last) state_nxt = DONE;
        else if (gap_last)       state_nxt = LOAD_W;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Beat counters, channel counters and running RAM addresses (weights are fully sequential).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_cnt        <= '0;
      p_cnt        <= '0;
      ch_in        <= '0;
      ch_out       <= '0;
      gap_cnt      <= '0;
      fmap_rd_addr <= '0;
      w_rd_addr    <= '0;
    end else begin
      case (state)
        IDLE: if (state_nxt == LOAD_W) begin
          k_cnt        <= '0;
          p_cnt        <= '0;
          ch_in        <= '0;
          ch_out       <= '0;
          gap_cnt      <= '0;
          fmap_rd_addr <= '0;
          w_rd_addr    <= '0;
        end
        LOAD_W: begin
          k_cnt     <= w_last ? '0 : k_cnt + 1'b1;
          w_rd_addr <= w_rd_addr + 1'b1;
        end
        LOAD_P: begin
          p_cnt        <= p_last ? '0 : p_cnt + 1'b1;
          fmap_rd_addr <= fmap_rd_addr + 1'b1;
        end
        NEXT: begin
          if (state_nxt == NEXT) begin
            gap_cnt <= gap_cnt + 1'b1;
          end else begin
            gap_cnt <= '0;
            ch_in   <= in_last ? '0 : ch_in + 1'b1;
            if (in_last) begin
              fmap_rd_addr <= '0;
              ch_out       <= out_last ? '0 : ch_out + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Two-stage output pipeline: strobe delay matches RAM latency, then register the beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_vld_q          <= 1'b0;
      p_vld_q          <= 1'b0;
      valid_weight_out <= 1'b0;
      valid_out        <= 1'b0;
      weight_out       <= '0;
      pxl_out          <= '0;
      done             <= 1'b0;
    end else begin
      w_vld_q          <= w_rd_en;
      p_vld_q          <= fmap_rd_en;
      valid_weight_out <= w_vld_q;
      valid_out        <= p_vld_q;
      if (w_vld_q) weight_out <= w_rd_data;
      if (p_vld_q) pxl_out    <= fmap_rd_data;
      done             <= (state == DONE);
    end
  end

endmodule

// File: tb/tb_conv_3x3_stream_feeder.sv
module tb_conv_3x3_stream_feeder;
  localparam int DW = 32, FAW = 8, WAW = 8, GAP = 3;
`ifdef FEEDER_PASS_GAP_EN
  localparam int EXP_GAP = GAP + 1;
`else
  localparam int EXP_GAP = 1;
`endif

  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic fmap_rd_en, w_rd_en, valid_out, valid_weight_out, busy, done;
  logic [FAW-1:0] fmap_rd_addr;
  logic [WAW-1:0] w_rd_addr;
  logic [DW-1:0]  fmap_rd_data = '0, w_rd_data = '0, pxl_out, weight_out;

  conv_3x3_stream_feeder #(
    .DATA_WIDTH(DW), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .CHANNEL_NUM_IN(2),
    .CHANNEL_NUM_OUT(2), .KERNEL(3), .FMAP_ADDR_WIDTH(FAW), .W_ADDR_WIDTH(WAW),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .fmap_rd_en(fmap_rd_en), .fmap_rd_addr(fmap_rd_addr), .fmap_rd_data(fmap_rd_data),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
    .valid_out(valid_out), .pxl_out(pxl_out),
    .valid_weight_out(valid_weight_out), .weight_out(weight_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // RAM models: each word holds its own address, one cycle read latency.
  always @(posedge clk) begin
    if (fmap_rd_en) fmap_rd_data <= DW'(fmap_rd_addr);
    if (w_rd_en)    w_rd_data    <= DW'(w_rd_addr);
  end

  int n_checks = 0, n_fail = 0;
  int cyc, w_cnt, p_cnt, done_cnt, ovl, strobes, done_cyc, last_p_cyc;
  logic busy_at_done, busy_at_last;
  int w_log[36], p_log[64], w_cyc[36], p_cyc[64];

  // Beat monitor, sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (valid_weight_out) begin
      if (w_cnt < 36) begin w_log[w_cnt] = weight_out; w_cyc[w_cnt] = cyc; end
      w_cnt++;
    end
    if (valid_out) begin
      if (p_cnt < 64) begin p_log[p_cnt] = pxl_out; p_cyc[p_cnt] = cyc; end
      p_cnt++;
      last_p_cyc   = cyc;
      busy_at_last = busy;
    end
    if (valid_out && valid_weight_out) ovl++;
    if (w_rd_en || fmap_rd_en) strobes++;
    if (done) begin done_cnt++; done_cyc = cyc; busy_at_done = busy; end
  end

  task automatic clear_mon();
    cyc = 0; w_cnt = 0; p_cnt = 0; done_cnt = 0; ovl = 0; strobes = 0;
    done_cyc = -1; last_p_cyc = -1; busy_at_done = 1'bx; busy_at_last = 1'bx;
    for (int i = 0; i < 36; i++) begin w_log[i] = -1; w_cyc[i] = -1; end
    for (int i = 0; i < 64; i++) begin p_log[i] = -1; p_cyc[i] = -1; end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "/valid_out"}, valid_out, 0);
    check({tag, "/valid_weight_out"}, valid_weight_out, 0);
    check({tag, "/pxl_out"}, pxl_out, 0);
    check({tag, "/weight_out"}, weight_out, 0);
    check({tag, "/busy"}, busy, 0);
    check({tag, "/done"}, done, 0);
    check({tag, "/rd_en"}, {w_rd_en, fmap_rd_en}, 0);
    check({tag, "/addr"}, {w_rd_addr, fmap_rd_addr}, 0);
  endtask

  // Called at a falling edge; leaves the bench at the next falling edge.
  task automatic pulse_start(input string tag);
    start = 1'b1;
    clear_mon();
    @(negedge clk);
    start = 1'b0;
    check({tag, "/busy_after_start"}, busy, 1);
    check({tag, "/w_rd_en_first"}, w_rd_en, 1);
    check({tag, "/w_rd_addr_first"}, w_rd_addr, 0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt > 0) begin seen = 1; break; end
    end
    check({tag, "/done_within_budget"}, seen, 1);
  endtask

  task automatic verify_layer(input string tag);
    check({tag, "/w_total"}, w_cnt, 36);
    check({tag, "/p_total"}, p_cnt, 64);
    check({tag, "/done_count"}, done_cnt, 1);
    check({tag, "/overlap"}, ovl, 0);
    check({tag, "/first_w_cycle"}, w_cyc[0], 3);
    check({tag, "/first_p_cycle"}, p_cyc[0], 12);
    check({tag, "/done_after_last_pixel"}, done_cyc, last_p_cyc + 1);
    check({tag, "/busy_at_last_beat"}, busy_at_last, 1);
    check({tag, "/busy_at_done"}, busy_at_done, 0);
    // Weight word i belongs to pass i/9 and has address i; pixels cycle ch_in 0,1,0,1.
    for (int i = 0; i < 36; i++) check($sformatf("%s/w_val[%0d]", tag, i), w_log[i], i);
    for (int j = 0; j < 64; j++)
      check($sformatf("%s/p_val[%0d]", tag, j), p_log[j], ((j / 16) % 2) * 16 + (j % 16));
    for (int n = 0; n < 4; n++) begin
      check($sformatf("%s/w_contig[%0d]", tag, n), w_cyc[9*n+8] - w_cyc[9*n], 8);
      check($sformatf("%s/p_contig[%0d]", tag, n), p_cyc[16*n+15] - p_cyc[16*n], 15);
      check($sformatf("%s/w_to_p[%0d]", tag, n), p_cyc[16*n] - w_cyc[9*n+8], 1);
      if (n < 3)
        check($sformatf("%s/pass_gap[%0d]", tag, n), w_cyc[9*(n+1)] - p_cyc[16*n+15] - 1, EXP_GAP);
    end
  endtask

  initial begin
    clear_mon();
    // Reset held, outputs idle.
    repeat (3) @(negedge clk);
    check_quiet("in_reset");
    // Release reset with start high on the same edge: must be ignored.
    reset = 1'b1;
    start = 1'b1;
    clear_mon();
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check_quiet("idle_after_reset");
    check("idle/strobes", strobes, 0);
    check("idle/beats", w_cnt + p_cnt + done_cnt, 0);

    // Full layer.
    pulse_start("layer1");
    wait_done("layer1", 400);
    repeat (5) @(negedge clk);
    verify_layer("layer1");
    check("layer1/busy_idle", busy, 0);

    // Layer with start re-pulsed mid-layer and again while in DONE.
    pulse_start("layer2");
    repeat (19) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (105 + 3 * (EXP_GAP - 1) - 21) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("layer2", 400);
    repeat (10) @(negedge clk);
    verify_layer("layer2");
    check("layer2/busy_idle", busy, 0);
    check("layer2/no_restart_strobes", w_rd_en | fmap_rd_en, 0);

    // Abort mid-LOAD_P of pass 0 with reset, then run a fresh layer.
    pulse_start("abort");
    repeat (14) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_quiet("abort_reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("abort/w_beats", w_cnt, 9);
    check("abort/p_beats", p_cnt, 4);
    check("abort/no_done", done_cnt, 0);
    check("abort/busy", busy, 0);
    pulse_start("layer3");
    wait_done("layer3", 400);
    repeat (5) @(negedge clk);
    verify_layer("layer3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
